stopwatch_core: RTL and testbench

- Consumer end of the divided-clock interface. Takes the CLK_FAST, CLK_2HZ and CLK_1HZ levels produced by the clock divider and samples them in the CLK_REF domain.
- Converts each rising edge of those levels into a single-cycle enable.
- Uses the enables to run a MM:SS stopwatch with pause and field-adjust modes.
- Scans the result onto a 4-digit multiplexed seven-segment display.
- Sits between the divider/button conditioning and the board display pins.

---
 rtl/stopwatch_core.sv | 170 +++++++++++++++++
 tb/tb_stopwatch_core.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// stopwatch_core
//   MM:SS stopwatch driven by divider levels sampled in the CLK_REF domain.
//   Counts on CLK_1HZ rises while running, adjusts one field on CLK_2HZ
//   rises while SW_ADJ is held, and scans a 4-digit multiplexed seven-
//   segment display on CLK_FAST rises.
//
// Ports
//   CLK_REF    system clock, all logic on its rising edge
//   CLK_RES    synchronous active-high reset
//   CLK_FAST   display scan level (CLK_REF-synchronous)
//   CLK_2HZ    adjust rate level (CLK_REF-synchronous)
//   CLK_1HZ    count rate level and blink level (CLK_REF-synchronous)
//   BTN_PAUSE  pause/run button level (asynchronous)
//   BTN_CLR    clear button level (asynchronous)
//   SW_ADJ     adjust mode switch (asynchronous)
//   SW_SEL     adjust field select, 0 = minutes, 1 = seconds (asynchronous)
//   AN         digit anodes, active-low one-hot
//   SEG        segments {g,f,e,d,c,b,a}, active-low
//   MIN, SEC   current minutes / seconds in binary
//
// state  | meaning
// -------+----------------------------------------------
// PAUSED | value held, pause rise starts counting
// RUN    | seconds advance on every CLK_1HZ rise
// ADJUST | SW_ADJ held, CLK_2HZ rises bump selected field
module stopwatch_core #(
    parameter int MAX_MIN = 59,
    parameter int MAX_SEC = 59
) (
    input  logic       CLK_REF,
    input  logic       CLK_RES,
    input  logic       CLK_FAST,
    input  logic       CLK_2HZ,
    input  logic       CLK_1HZ,
    input  logic       BTN_PAUSE,
    input  logic       BTN_CLR,
    input  logic       SW_ADJ,
    input  logic       SW_SEL,
    output logic [3:0] AN,
    output logic [6:0] SEG,
    output logic [6:0] MIN,
    output logic [6:0] SEC
);

    localparam logic [6:0] MAX_MIN_V = 7'(MAX_MIN);
    localparam logic [6:0] MAX_SEC_V = 7'(MAX_SEC);

    typedef enum logic [1:0] {PAUSED, RUN, ADJUST} state_t;

    state_t     state;
    logic [1:0] pause_sync, clr_sync, adj_sync, sel_sync;
    logic       pause_prev, clr_prev;
    logic       fast_prev, hz2_prev, hz1_prev;
    logic       en_fast, en_2hz, en_1hz;
    logic       pause_rise, clr_rise, adj_on, sel_sec;
    logic [1:0] scan_idx;
    logic [6:0] field_val;
    logic [3:0] digit;
    logic       blank;

    // Button/switch synchronizers, edge history, and divider rise enables.
    // Divider enables are registered so the counters see a clean one-cycle
    // pulse on the edge after the level is first sampled high.
    always_ff @(posedge CLK_REF) begin
        if (CLK_RES) begin
            pause_sync <= '0;
            clr_sync   <= '0;
            adj_sync   <= '0;
            sel_sync   <= '0;
            pause_prev <= 1'b0;
            clr_prev   <= 1'b0;
            fast_prev  <= 1'b0;
            hz2_prev   <= 1'b0;
            hz1_prev   <= 1'b0;
            en_fast    <= 1'b0;
            en_2hz     <= 1'b0;
            en_1hz     <= 1'b0;
        end else begin
            pause_sync <= {pause_sync[0], BTN_PAUSE};
            clr_sync   <= {clr_sync[0], BTN_CLR};
            adj_sync   <= {adj_sync[0], SW_ADJ};
            sel_sync   <= {sel_sync[0], SW_SEL};
            pause_prev <= pause_sync[1];
            clr_prev   <= clr_sync[1];
            fast_prev  <= CLK_FAST;
            hz2_prev   <= CLK_2HZ;
            hz1_prev   <= CLK_1HZ;
            en_fast    <= CLK_FAST & ~fast_prev;
            en_2hz     <= CLK_2HZ & ~hz2_prev;
            en_1hz     <= CLK_1HZ & ~hz1_prev;
        end
    end

    assign pause_rise = pause_sync[1] & ~pause_prev;
    assign clr_rise   = clr_sync[1] & ~clr_prev;
    assign adj_on     = adj_sync[1];
    assign sel_sec    = sel_sync[1];

    // Mode FSM and time registers. Clear wins over any same-cycle increment.
    always_ff @(posedge CLK_REF) begin
        if (CLK_RES) begin
            state <= PAUSED;
            MIN   <= '0;
            SEC   <= '0;
        end else begin
            case (state)
                PAUSED:  if (adj_on) state <= ADJUST;
                         else if (pause_rise) state <= RUN;
                RUN:     if (adj_on) state <= ADJUST;
                         else if (pause_rise) state <= PAUSED;
                ADJUST:  if (!adj_on) state <= PAUSED;
                default: state <= PAUSED;
            endcase

            if (clr_rise) begin
                MIN <= '0;
                SEC <= '0;
            end else if (state == RUN && en_1hz) begin
                if (SEC == MAX_SEC_V) begin
                    SEC <= '0;
                    MIN <= (MIN == MAX_MIN_V) ? 7'd0 : MIN + 7'd1;
                end else begin
                    SEC <= SEC + 7'd1;
                end
            end else if (state == ADJUST && en_2hz) begin
                if (sel_sec)
                    SEC <= (SEC == MAX_SEC_V) ? 7'd0 : SEC + 7'd1;
                else
                    MIN <= (MIN == MAX_MIN_V) ? 7'd0 : MIN + 7'd1;
            end
        end
    end

    // Index bit 1 picks the field (0 = seconds), bit 0 picks tens over ones.
    // The selected field blanks while adjusting and the blink level is high.
    always_comb begin
        field_val = scan_idx[1] ? MIN : SEC;
        digit     = scan_idx[0] ? 4'(field_val / 7'd10) : 4'(field_val % 7'd10);
        blank     = (state == ADJUST) && CLK_1HZ && (scan_idx[1] == ~sel_sec);
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge CLK_REF) begin
        if (CLK_RES) begin
            scan_idx <= '0;
            AN       <= 4'b1110;
            SEG      <= 7'b1000000;
        end else begin
            if (en_fast) scan_idx <= scan_idx + 2'd1;
            AN  <= ~(4'b0001 << scan_idx);
            SEG <= blank ? 7'b1111111 : seg_of(digit);
        end
    end

endmodule

// File: tb/tb_stopwatch_core.sv
module tb_stopwatch_core;

    localparam int MM = 59;
    localparam int MS = 59;

    typedef enum int {OP_TICK, OP_ADJ2, OP_PAUSE, OP_CLR, OP_ADJ, OP_SEL, OP_FAST, OP_L1} op_t;
    typedef struct {
        op_t op;
        bit  arg;
        int  em;
        int  es;
    } vec_t;

    logic clk = 1'b0, rst = 1'b0;
    logic fast = 1'b0, hz2 = 1'b0, hz1 = 1'b0;
    logic bp = 1'b0, bc = 1'b0, sa = 1'b0, ss = 1'b0;
    logic [3:0] an;
    logic [6:0] seg, mn, sc;

    always #5 clk = ~clk;

    stopwatch_core #(.MAX_MIN(MM), .MAX_SEC(MS)) dut (
        .CLK_REF(clk), .CLK_RES(rst), .CLK_FAST(fast), .CLK_2HZ(hz2), .CLK_1HZ(hz1),
        .BTN_PAUSE(bp), .BTN_CLR(bc), .SW_ADJ(sa), .SW_SEL(ss),
        .AN(an), .SEG(seg), .MIN(mn), .SEC(sc)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: time as plain numbers, mode 0 = paused, 1 = run, 2 = adjust.
    int   m_min, m_sec, m_state, m_idx;
    logic m_sel, m_lvl1;

    vec_t       tbl [16];
    logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] exp_seg [4] = '{7'b1111000, 7'b1111001, 7'b0100100, 7'b0011001};
    logic [6:0] exp_blk [4] = '{7'b1111000, 7'b1111001, 7'b1111111, 7'b1111111};

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_pat(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    task automatic m_reset();
        m_min = 0; m_sec = 0; m_state = 0; m_idx = 0; m_lvl1 = 1'b0; m_sel = ss;
    endtask

    task automatic m_rise1();
        int t;
        if (m_state == 1) begin
            t = (m_min * (MS + 1) + m_sec + 1) % ((MM + 1) * (MS + 1));
            m_min = t / (MS + 1);
            m_sec = t % (MS + 1);
        end
    endtask

    task automatic m_rise2();
        if (m_state == 2) begin
            if (m_sel) m_sec = (m_sec + 1) % (MS + 1);
            else       m_min = (m_min + 1) % (MM + 1);
        end
    endtask

    task automatic chk_model(input string tag);
        logic [3:0] ea;
        logic [6:0] es;
        int v, d;
        logic blank;
        ea = ~(4'b0001 << m_idx);
        v = (m_idx >= 2) ? m_min : m_sec;
        d = (m_idx % 2 == 1) ? v / 10 : v % 10;
        blank = (m_state == 2) && m_lvl1 && (m_sel ? (m_idx < 2) : (m_idx >= 2));
        es = blank ? 7'b1111111 : seg_pat(d);
        chk({tag, "_min"}, int'(mn), m_min);
        chk({tag, "_sec"}, int'(sc), m_sec);
        chk({tag, "_an"}, int'(an), int'(ea));
        chk({tag, "_seg"}, int'(seg), int'(es));
    endtask

    task automatic do_op(input op_t op, input bit arg);
        case (op)
            OP_TICK: begin
                if (hz1) begin hz1 = 1'b0; step(3); end
                hz1 = 1'b1; m_rise1(); step(3);
                hz1 = 1'b0; m_lvl1 = 1'b0; step(3);
            end
            OP_L1: begin
                if (arg && !hz1) m_rise1();
                hz1 = arg; m_lvl1 = arg; step(4);
            end
            OP_ADJ2: begin
                hz2 = 1'b1; m_rise2(); step(3);
                hz2 = 1'b0; step(3);
            end
            OP_FAST: begin
                fast = 1'b1; m_idx = (m_idx + 1) % 4; step(3);
                fast = 1'b0; step(3);
            end
            OP_PAUSE: begin
                bp = 1'b1;
                if (m_state != 2) m_state = (m_state == 1) ? 0 : 1;
                step(5);
                bp = 1'b0; step(5);
            end
            OP_CLR: begin
                bc = 1'b1; m_min = 0; m_sec = 0; step(5);
                bc = 1'b0; step(5);
            end
            OP_ADJ: begin
                sa = arg;
                if (arg) m_state = 2;
                else if (m_state == 2) m_state = 0;
                step(5);
            end
            default: begin
                ss = arg; m_sel = arg; step(5);
            end
        endcase
    endtask

    task automatic set_time(input int mm, input int ssec);
        do_op(OP_CLR, 1'b0);
        do_op(OP_ADJ, 1'b1);
        do_op(OP_SEL, 1'b0);
        repeat (mm) do_op(OP_ADJ2, 1'b0);
        do_op(OP_SEL, 1'b1);
        repeat (ssec) do_op(OP_ADJ2, 1'b0);
        do_op(OP_ADJ, 1'b0);
    endtask

    task automatic do_reset();
        fast = 1'b0; hz2 = 1'b0; hz1 = 1'b0; bp = 1'b0; bc = 1'b0; sa = 1'b0;
        rst = 1'b1; step(3);
        rst = 1'b0; m_reset(); step(2);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1);
    end

    initial begin
        tbl = '{
            '{OP_PAUSE, 1'b0, 0, 0}, '{OP_TICK, 1'b0, 0, 1}, '{OP_TICK, 1'b0, 0, 2},
            '{OP_PAUSE, 1'b0, 0, 2}, '{OP_TICK, 1'b0, 0, 2}, '{OP_ADJ, 1'b1, 0, 2},
            '{OP_ADJ2, 1'b0, 1, 2},  '{OP_SEL, 1'b1, 1, 2},  '{OP_ADJ2, 1'b0, 1, 3},
            '{OP_TICK, 1'b0, 1, 3},  '{OP_ADJ, 1'b0, 1, 3},  '{OP_TICK, 1'b0, 1, 3},
            '{OP_PAUSE, 1'b0, 1, 3}, '{OP_TICK, 1'b0, 1, 4}, '{OP_CLR, 1'b0, 0, 0},
            '{OP_TICK, 1'b0, 0, 1}
        };

        // Reset held 3 cycles while the count level toggles.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            hz1 = ~hz1;
            step(1);
        end
        chk("rst_min", int'(mn), 0);
        chk("rst_sec", int'(sc), 0);
        chk("rst_an", int'(an), int'(4'b1110));
        chk("rst_seg", int'(seg), int'(7'b1000000));
        rst = 1'b0; hz1 = 1'b0; m_reset(); step(2);
        for (int i = 0; i < 4; i++) do_op(OP_TICK, 1'b0);
        chk_model("rst_nocount");

        // Directed table of operations.
        for (int i = 0; i < 16; i++) begin
            do_op(tbl[i].op, tbl[i].arg);
            chk($sformatf("tbl%0d_min", i), int'(mn), tbl[i].em);
            chk($sformatf("tbl%0d_sec", i), int'(sc), tbl[i].es);
        end

        // Full wrap with fast 2-cycle rises, then latency of the final rise.
        do_reset();
        do_op(OP_PAUSE, 1'b0);
        for (int i = 0; i < 3599; i++) begin
            hz1 = 1'b1; step(1);
            hz1 = 1'b0; step(1);
            m_rise1();
        end
        step(2);
        chk("wrap_min_pre", int'(mn), 59);
        chk("wrap_sec_pre", int'(sc), 59);
        hz1 = 1'b1; step(1);
        chk("lat_hold_sec", int'(sc), 59);
        step(1);
        m_rise1();
        chk("wrap_min", int'(mn), 0);
        chk("wrap_sec", int'(sc), 0);
        hz1 = 1'b0; step(2);
        chk_model("wrap");

        // Clear landing on the same cycle as a count tick.
        set_time(12, 34);
        do_op(OP_PAUSE, 1'b0);
        chk("pre_clr_min", int'(mn), 12);
        chk("pre_clr_sec", int'(sc), 34);
        bc = 1'b1; step(1);
        hz1 = 1'b1; step(1);
        step(1);
        chk("clr_pri_min", int'(mn), 0);
        chk("clr_pri_sec", int'(sc), 0);
        m_min = 0; m_sec = 0;
        hz1 = 1'b0; step(3);
        bc = 1'b0; step(5);
        do_op(OP_TICK, 1'b0);
        chk("clr_run_sec", int'(sc), 1);
        chk_model("clr");

        // Display scan of 42:17, then blink of the minutes field.
        set_time(42, 17);
        while (m_idx != 3) do_op(OP_FAST, 1'b0);
        for (int i = 0; i < 4; i++) begin
            do_op(OP_FAST, 1'b0);
            chk($sformatf("scan%0d_an", i), int'(an), int'(exp_an[i]));
            chk($sformatf("scan%0d_seg", i), int'(seg), int'(exp_seg[i]));
        end
        do_op(OP_ADJ, 1'b1);
        do_op(OP_SEL, 1'b0);
        do_op(OP_L1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            do_op(OP_FAST, 1'b0);
            chk($sformatf("blink%0d_an", i), int'(an), int'(exp_an[i]));
            chk($sformatf("blink%0d_seg", i), int'(seg), int'(exp_blk[i]));
        end
        do_op(OP_L1, 1'b0);
        do_op(OP_ADJ, 1'b0);
        chk_model("blink_done");

        // Reset while adjusting.
        do_op(OP_ADJ, 1'b1);
        repeat (3) do_op(OP_ADJ2, 1'b0);
        rst = 1'b1; step(2);
        chk("rst_adj_min", int'(mn), 0);
        chk("rst_adj_sec", int'(sc), 0);
        chk("rst_adj_an", int'(an), int'(4'b1110));
        do_reset();
        chk_model("rst_adj");

        // Randomized operations near the wrap point against the model.
        set_time(59, 57);
        do_op(OP_PAUSE, 1'b0);
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2: do_op(OP_TICK, 1'b0);
                3:       do_op(OP_ADJ2, 1'b0);
                4:       do_op(OP_PAUSE, 1'b0);
                5:       if ($urandom_range(0, 2) == 0) do_op(OP_CLR, 1'b0);
                         else do_op(OP_TICK, 1'b0);
                6:       do_op(OP_ADJ, 1'($urandom_range(0, 1)));
                7:       do_op(OP_SEL, 1'($urandom_range(0, 1)));
                8:       do_op(OP_FAST, 1'b0);
                default: do_op(OP_L1, 1'($urandom_range(0, 1)));
            endcase
            chk_model($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
